// File: rtl/comparer_scheduler.sv
// Round-robin arbiter sharing the key cache comparer's single compare port
// between NUM_REQ requesters; the hit vector is returned only to the issuer.
//
// state    | meaning
// IDLE     | arbitrating; req_ready pulses for the winner
// ISSUE    | latched key offered to the comparer
// WAIT_RES | waiting for the comparer's hit vector
// RESP     | hit vector held for the granted requester
module comparer_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int CACHE_DEPTH = 8,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                    axis_clk,
  input  logic                    axis_rstn,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*64-1:0]   req_key,
  input  logic [NUM_REQ-1:0]      req_opcode,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [CACHE_DEPTH-1:0]  rsp_result,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic                    compare_key_valid,
  output logic [63:0]             compare_key,
  output logic                    compare_opcode,
  input  logic                    compare_key_ready,
  input  logic                    result_valid,
  input  logic [CACHE_DEPTH-1:0]  result,
  output logic                    result_ready,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    busy,
  output logic [31:0]             hit_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] winner;
  logic             found;

  // Search upward from last_grant+1 with wrap; NUM_REQ need not be a power of 2.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[winner] = 1'b1;
  end

  assign result_ready = (state == WAIT_RES);
  assign busy         = (state != IDLE);

  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      state             <= IDLE;
      last_grant        <= IDX_W'(NUM_REQ - 1);
      grant_idx         <= '0;
      compare_key_valid <= 1'b0;
      compare_key       <= '0;
      compare_opcode    <= 1'b0;
      rsp_valid         <= '0;
      rsp_result        <= '0;
      hit_count         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            compare_key       <= req_key[int'(winner)*64 +: 64];
            compare_opcode    <= req_opcode[winner];
            grant_idx         <= winner;
            compare_key_valid <= 1'b1;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          if (compare_key_ready) begin
            compare_key_valid <= 1'b0;
            state             <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (result_valid) begin
            rsp_result            <= result;
            rsp_valid             <= '0;
            rsp_valid[grant_idx]  <= 1'b1;
            if (result != '0 && hit_count != 32'hFFFF_FFFF)
              hit_count <= hit_count + 32'd1;
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[grant_idx]) begin
            rsp_valid  <= '0;
            last_grant <= grant_idx;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparer_scheduler.sv
// Bench for comparer_scheduler: table of transactions with a behavioural
// comparer/requester, plus a hand-written mid-transaction reset sequence.
module tb_comparer_scheduler;

  localparam int NUM_REQ = 4;
  localparam int CD      = 8;

  logic                   clk, rstn;
  logic [NUM_REQ-1:0]     req_valid, req_opcode, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ*64-1:0]  req_key;
  logic [CD-1:0]          rsp_result, result;
  logic                   compare_key_valid, compare_opcode, compare_key_ready;
  logic [63:0]            compare_key;
  logic                   result_valid, result_ready, busy;
  logic [1:0]             grant_idx;
  logic [31:0]            hit_count;

  comparer_scheduler #(.NUM_REQ(NUM_REQ), .CACHE_DEPTH(CD)) dut (
    .axis_clk(clk), .axis_rstn(rstn),
    .req_valid(req_valid), .req_key(req_key), .req_opcode(req_opcode),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_ready(rsp_ready), .compare_key_valid(compare_key_valid),
    .compare_key(compare_key), .compare_opcode(compare_opcode),
    .compare_key_ready(compare_key_ready), .result_valid(result_valid),
    .result(result), .result_ready(result_ready), .grant_idx(grant_idx),
    .busy(busy), .hit_count(hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vmask;
    logic [3:0] ops;
    int         cmp_stall;
    int         rsp_stall;
    int         g;
    logic [7:0] res;
  } vec_t;

  typedef struct {
    int         g;
    logic [7:0] res;
  } exp_t;

  vec_t       vecs[14];
  exp_t       sb[$];
  int         total = 0;
  int         passed = 0;
  logic [31:0] hit_exp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] key_of(input int i, input int t);
    return {32'hDEADBEEF, 8'(t), 16'h0000, 8'(i + 1)};
  endfunction

  task automatic run_txn(input vec_t v, input int t);
    logic [63:0] k;
    logic [7:0]  r;
    logic [3:0]  gmask;
    exp_t        e;
    bit          got;
    gmask = 4'b0001 << v.g;
    k = key_of(v.g, t);
    r = v.ops[v.g] ? 8'h00 : v.res;
    @(negedge clk);
    rsp_ready = '0;
    chk("idle_busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < NUM_REQ; i++) req_key[64*i +: 64] = key_of(i, t);
    req_opcode = v.ops;
    req_valid  = v.vmask;
    #1;
    got = 0;
    for (int w = 0; w < 4 && !got; w++) begin
      if (req_ready != '0) got = 1;
      else begin @(negedge clk); #1; end
    end
    chk("grant", {60'd0, req_ready}, {60'd0, gmask});
    if (!got) return;
    e.g = v.g; e.res = r;
    sb.push_back(e);
    @(negedge clk);
    req_valid = v.vmask & ~gmask;
    for (int c = 0; c <= v.cmp_stall; c++) begin
      if (c > 0) @(negedge clk);
      compare_key_ready = (c == v.cmp_stall);
      #1;
      chk("cmp_valid", {63'd0, compare_key_valid}, 64'd1);
      chk("cmp_key", compare_key, k);
      chk("cmp_op", {63'd0, compare_opcode}, {63'd0, v.ops[v.g]});
      chk("issue_no_ready", {60'd0, req_ready}, 64'd0);
      if (c == 0) chk("grant_idx", {62'd0, grant_idx}, 64'(v.g));
    end
    @(negedge clk);
    compare_key_ready = 1'b0;
    result_valid = 1'b1;
    result = r;
    #1;
    chk("res_ready", {63'd0, result_ready}, 64'd1);
    chk("cmp_valid_drop", {63'd0, compare_key_valid}, 64'd0);
    for (int c = 0; c <= v.rsp_stall; c++) begin
      @(negedge clk);
      result_valid = 1'b0;
      result = 8'hFF;
      rsp_ready = (c == v.rsp_stall) ? gmask : ~gmask;
      #1;
      if (c == 0) begin
        if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          if (e.res != 0) hit_exp = hit_exp + 1;
          chk("rsp_valid", {60'd0, rsp_valid}, {60'd0, 4'b0001 << e.g});
          chk("rsp_result", {56'd0, rsp_result}, {56'd0, e.res});
          chk("hit_count", {32'd0, hit_count}, {32'd0, hit_exp});
        end
      end else begin
        chk("rsp_valid_hold", {60'd0, rsp_valid}, {60'd0, gmask});
        chk("rsp_result_hold", {56'd0, rsp_result}, {56'd0, r});
      end
      chk("resp_no_ready", {60'd0, req_ready}, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'b0001, 4'b0000, 0, 0, 0, 8'h04};
    vecs[1]  = '{4'b1111, 4'b0000, 0, 0, 1, 8'h01};
    vecs[2]  = '{4'b1111, 4'b0000, 0, 0, 2, 8'h00};
    vecs[3]  = '{4'b1111, 4'b0000, 1, 0, 3, 8'h80};
    vecs[4]  = '{4'b1111, 4'b0000, 0, 1, 0, 8'h10};
    vecs[5]  = '{4'b1111, 4'b0000, 0, 0, 1, 8'h22};
    vecs[6]  = '{4'b1111, 4'b0000, 0, 0, 2, 8'h00};
    vecs[7]  = '{4'b1111, 4'b0000, 2, 2, 3, 8'hC3};
    vecs[8]  = '{4'b1111, 4'b0000, 0, 0, 0, 8'h07};
    vecs[9]  = '{4'b0010, 4'b0010, 0, 0, 1, 8'h5A};
    vecs[10] = '{4'b0100, 4'b0000, 5, 3, 2, 8'h22};
    vecs[11] = '{4'b1000, 4'b0000, 0, 0, 3, 8'h08};
    vecs[12] = '{4'b0100, 4'b0000, 0, 0, 2, 8'h40};
    vecs[13] = '{4'b0011, 4'b0000, 0, 0, 0, 8'h03};

    rstn = 1'b0;
    req_valid = '0; req_key = '0; req_opcode = '0; rsp_ready = '0;
    compare_key_ready = 1'b0; result_valid = 1'b0; result = '0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_cmp_valid", {63'd0, compare_key_valid}, 64'd0);
    chk("rst_hit", {32'd0, hit_count}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int t = 0; t < 14; t++) run_txn(vecs[t], t);

    // Abort a transaction in WAIT_RES with an asynchronous reset.
    @(negedge clk);
    rsp_ready = '0;
    req_valid = 4'b0010;
    #1;
    chk("pre_rst_grant", {60'd0, req_ready}, 64'h2);
    @(negedge clk);
    req_valid = '0;
    compare_key_ready = 1'b1;
    @(negedge clk);
    compare_key_ready = 1'b0;
    #1;
    chk("pre_rst_wait", {63'd0, result_ready}, 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_res_ready", {63'd0, result_ready}, 64'd0);
    chk("arst_rsp_valid", {60'd0, rsp_valid}, 64'd0);
    chk("arst_rsp_result", {56'd0, rsp_result}, 64'd0);
    chk("arst_cmp_key", compare_key, 64'd0);
    chk("arst_cmp_op", {63'd0, compare_opcode}, 64'd0);
    chk("arst_grant_idx", {62'd0, grant_idx}, 64'd0);
    chk("arst_hit", {32'd0, hit_count}, 64'd0);
    chk("arst_req_ready", {60'd0, req_ready}, 64'd0);
    sb.delete();
    hit_exp = 0;
    @(negedge clk);
    rstn = 1'b1;
    run_txn('{4'b1111, 4'b0000, 0, 0, 0, 8'h11}, 20);
    @(negedge clk);
    rsp_ready = '0;
    req_valid = '0;
    #1;
    chk("end_idle", {63'd0, busy}, 64'd0);
    chk("end_rsp_valid", {60'd0, rsp_valid}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
